sobel_edge_detector: RTL and testbench
======================================

Name: sobel_edge_detector

Overview:
- Downstream consumer of the 3x3 window generator.
- Takes the nine window taps plus the delayed VSYNC/HSYNC/BLANK and computes a Sobel gradient magnitude per pixel in a 3-stage pipeline.
- Compares the magnitude against a frame-stable threshold to produce a binary edge map.
- Keeps a per-frame edge-pixel count for the host or statistics path.
- Output syncs are realigned to the pipeline latency so the next stage (display mux / binary morphology) sees a coherent stream.

Parameters:
- DATA_WIDTH, 8: pixel/tap width; o_mag width.
- CNT_WIDTH, 20: edge-counter width; must cover 640x480 = 307200.
- THRESH_DEFAULT, 8'd64: threshold value after reset, zero-extended/truncated to DATA_WIDTH.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_VSYNC  in  1  frame sync from window generator; a rising edge marks a frame boundary.
- i_HSYNC  in  1  line sync.
- i_BLANK  in  1  active-high pixel-valid; taps are meaningful only when high.
- i_matrix11..i_matrix33  in  DATA_WIDTH each  window taps; row 1 is oldest line, column 1 is oldest pixel.
- i_threshold  in  DATA_WIDTH  requested edge threshold.
- o_VSYNC, o_HSYNC, o_BLANK  out  1 each  input syncs delayed exactly 3 cycles.
- o_mag  out  DATA_WIDTH  saturated |Gx|+|Gy|.
- o_edge  out  1  1 when o_mag >= active threshold and o_BLANK=1.
- o_edge_count  out  CNT_WIDTH  edge pixels in the last completed frame.
- o_count_valid  out  1  one-cycle pulse when o_edge_count updates.

Behaviour:
- Reset (async, rst_n=0):
  - All pipeline registers and all outputs are 0.
  - Active threshold = THRESH_DEFAULT.
  - Edge counter = 0.
  - VSYNC edge detectors = 0.
- Stage 1 (registered), DATA_WIDTH+2 bits, unsigned:
  - gx_p = m13 + 2·m23 + m33
  - gx_n = m11 + 2·m21 + m31
  - gy_p = m31 + 2·m32 + m33
  - gy_n = m11 + 2·m12 + m13
- Stage 2 (registered), DATA_WIDTH+2 bits:
  - ax = |gx_p − gx_n|, ay = |gy_p − gy_n|.
  - Each is computed as the larger minus the smaller; no signed wrap.
- Stage 3 (registered):
  - sum = ax + ay, DATA_WIDTH+3 bits.
  - o_mag = sum if sum ≤ 2^DATA_WIDTH−1, else 2^DATA_WIDTH−1.
  - o_edge = (saturated mag ≥ active threshold) AND the stage-2 delayed BLANK.
- Blanking: when the delayed BLANK is 0, stage 3 forces o_mag=0 and o_edge=0, whatever the tap contents.
- Latency: a tap set presented at cycle N appears on o_mag/o_edge at N+3. o_VSYNC/o_HSYNC/o_BLANK are 3-deep shift registers of the inputs, so all outputs stay aligned.
- Pipeline runs every cycle; there is no stall or backpressure.
- Threshold latch:
  - Input-side rising edge of i_VSYNC (i_VSYNC=1, previous=0) loads i_threshold into the active threshold on that clock.
  - Changes to i_threshold at any other time are ignored until the next frame boundary.
  - The new threshold applies to the first pixel whose taps enter at or after the latch cycle, consistent with the 3-cycle pipe.
- Edge counter, output-side domain:
  - A rising edge of o_VSYNC (detected against its own registered copy) closes the frame: o_edge_count ← counter, o_count_valid=1 for exactly one cycle, and the counter is cleared.
  - If o_edge=1 on that same cycle, the counter loads 1 instead of 0.
  - Otherwise the counter increments by 1 on each cycle with o_edge=1.
  - The counter saturates at 2^CNT_WIDTH−1; it never wraps.
  - o_edge_count holds its value between frame boundaries.
- First frame after reset: the first o_VSYNC rising edge publishes whatever the counter accumulated since reset, including 0.
- Reset mid-frame: all state clears immediately. No count_valid pulse is issued for the truncated frame. The next o_VSYNC rise publishes a partial count.
- Simultaneous input-side and output-side VSYNC events are independent; both take effect on the same clock.

Test Plan:
- Reset release, flat taps all 100, BLANK=1 → o_mag=0 and o_edge=0 from cycle 3 onward; syncs match inputs delayed by 3.
- DATA_WIDTH=8, columns 1=0 and 3=255 in all rows, column 2=128 → Gx=1020, Gy=0, o_mag=255 (saturated), o_edge=1 at threshold 64, exactly 3 cycles after taps.
- m13=m23=m33=10, others 0 → o_mag=40.
  - Threshold 40 latched → o_edge=1.
  - Threshold 41 latched at next VSYNC rise → o_edge=0.
  - Changing i_threshold to 41 mid-frame without a VSYNC rise leaves o_edge=1.
- Frame of 640 valid pixels with 5 edge pixels, then VSYNC pulse → at o_VSYNC rise o_edge_count=5 and o_count_valid high for 1 cycle. The next frame with 0 edges publishes 0.
- Edge pixel coinciding with the o_VSYNC rise → published count excludes it; the following frame's count includes it (starts at 1).
- Step taps present but i_BLANK=0 → o_mag=0, o_edge=0, counter unchanged.
- Assert rst_n mid-frame after 3 edges → outputs 0 and threshold=64 immediately; no o_count_valid until the next o_VSYNC rise.

Source files
------------

// File: rtl/sobel_edge_detector.sv
// Sobel edge detector: |Gx|+|Gy| magnitude, threshold to a binary edge map, per-frame edge count.
// Latency: 3 cycles from taps/syncs in to o_mag/o_edge/syncs out; the count publishes 1 cycle after the o_VSYNC rise.
// Backpressure: none; the pipeline advances every clock, like the pixel stream feeding it.
//
// Ports:
//   clk, rst_n                         pixel clock, async active-low reset
//   i_VSYNC/i_HSYNC/i_BLANK            syncs from the window generator (BLANK=1 means pixel valid)
//   i_matrix11..i_matrix33             3x3 window taps (row 1 oldest line, column 1 oldest pixel)
//   i_threshold                        requested threshold, sampled on each i_VSYNC rise
//   o_VSYNC/o_HSYNC/o_BLANK            input syncs delayed 3 cycles
//   o_mag, o_edge                      saturated magnitude and edge flag
//   o_edge_count, o_count_valid        edge pixels of the last completed frame, and its update strobe
module sobel_edge_detector #(
    parameter int          DATA_WIDTH     = 8,
    parameter int          CNT_WIDTH      = 20,
    parameter logic [7:0]  THRESH_DEFAULT = 8'd64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_VSYNC,
    input  logic                  i_HSYNC,
    input  logic                  i_BLANK,
    input  logic [DATA_WIDTH-1:0] i_matrix11,
    input  logic [DATA_WIDTH-1:0] i_matrix12,
    input  logic [DATA_WIDTH-1:0] i_matrix13,
    input  logic [DATA_WIDTH-1:0] i_matrix21,
    input  logic [DATA_WIDTH-1:0] i_matrix22,
    input  logic [DATA_WIDTH-1:0] i_matrix23,
    input  logic [DATA_WIDTH-1:0] i_matrix31,
    input  logic [DATA_WIDTH-1:0] i_matrix32,
    input  logic [DATA_WIDTH-1:0] i_matrix33,
    input  logic [DATA_WIDTH-1:0] i_threshold,
    output logic                  o_VSYNC,
    output logic                  o_HSYNC,
    output logic                  o_BLANK,
    output logic [DATA_WIDTH-1:0] o_mag,
    output logic                  o_edge,
    output logic [CNT_WIDTH-1:0]  o_edge_count,
    output logic                  o_count_valid
);

    localparam int GW = DATA_WIDTH + 2;   // one-sided Sobel sum: up to 4*max
    localparam int SW = DATA_WIDTH + 3;   // |Gx|+|Gy|: up to 8*max

    localparam logic [DATA_WIDTH-1:0] THR_RST = DATA_WIDTH'(THRESH_DEFAULT);
    localparam logic [DATA_WIDTH-1:0] MAG_MAX = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

    // The centre tap has zero weight in both kernels, so i_matrix22 is only
    // carried for port symmetry with the window generator.
    logic unused_center;
    assign unused_center = ^i_matrix22;

    // ------------------------------------------------------------------
    // Stage 1: positive and negative halves of each kernel, kept unsigned
    // ------------------------------------------------------------------
    logic [GW-1:0] gx_p_c, gx_n_c, gy_p_c, gy_n_c;
    assign gx_p_c = GW'(i_matrix13) + (GW'(i_matrix23) << 1) + GW'(i_matrix33);
    assign gx_n_c = GW'(i_matrix11) + (GW'(i_matrix21) << 1) + GW'(i_matrix31);
    assign gy_p_c = GW'(i_matrix31) + (GW'(i_matrix32) << 1) + GW'(i_matrix33);
    assign gy_n_c = GW'(i_matrix11) + (GW'(i_matrix12) << 1) + GW'(i_matrix13);

    logic [GW-1:0] gx_p, gx_n, gy_p, gy_n;
    logic [GW-1:0] ax, ay;

    // Sync delay lines; index 1 is the stage-2 copy used to gate stage 3.
    logic [2:0] vs_sr, hs_sr, bl_sr;

    // Input-side frame boundary detection and threshold latch.
    logic                  vs_in_q;
    logic                  thr_latch;
    logic [DATA_WIDTH-1:0] thr_active;
    // Threshold travels with the pixel so a new value takes effect exactly
    // on the first tap set entering on or after the latch cycle.
    logic [DATA_WIDTH-1:0] thr_s1, thr_s2;

    assign thr_latch = i_VSYNC & ~vs_in_q;

    // ------------------------------------------------------------------
    // Stage 3 combinational: sum and saturate
    // ------------------------------------------------------------------
    logic [SW-1:0]         sum_c;
    logic [DATA_WIDTH-1:0] mag_sat_c;
    assign sum_c     = SW'(ax) + SW'(ay);
    assign mag_sat_c = (sum_c > SW'(MAG_MAX)) ? MAG_MAX : sum_c[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_p       <= '0;
            gx_n       <= '0;
            gy_p       <= '0;
            gy_n       <= '0;
            ax         <= '0;
            ay         <= '0;
            vs_sr      <= '0;
            hs_sr      <= '0;
            bl_sr      <= '0;
            vs_in_q    <= 1'b0;
            thr_active <= THR_RST;
            thr_s1     <= THR_RST;
            thr_s2     <= THR_RST;
            o_mag      <= '0;
            o_edge     <= 1'b0;
        end else begin
            // stage 1
            gx_p <= gx_p_c;
            gx_n <= gx_n_c;
            gy_p <= gy_p_c;
            gy_n <= gy_n_c;

            vs_in_q <= i_VSYNC;
            if (thr_latch) begin
                thr_active <= i_threshold;
            end
            thr_s1 <= thr_latch ? i_threshold : thr_active;

            // stage 2: larger minus smaller avoids any signed wrap
            ax     <= (gx_p >= gx_n) ? (gx_p - gx_n) : (gx_n - gx_p);
            ay     <= (gy_p >= gy_n) ? (gy_p - gy_n) : (gy_n - gy_p);
            thr_s2 <= thr_s1;

            // stage 3: blanked pixels never report magnitude or edges
            o_mag  <= bl_sr[1] ? mag_sat_c : '0;
            o_edge <= bl_sr[1] && (mag_sat_c >= thr_s2);

            vs_sr <= {vs_sr[1:0], i_VSYNC};
            hs_sr <= {hs_sr[1:0], i_HSYNC};
            bl_sr <= {bl_sr[1:0], i_BLANK};
        end
    end

    assign o_VSYNC = vs_sr[2];
    assign o_HSYNC = hs_sr[2];
    assign o_BLANK = bl_sr[2];

    // ------------------------------------------------------------------
    // Output-side edge counter, framed by the realigned VSYNC
    // ------------------------------------------------------------------
    logic                 vs_out_q;
    logic                 frame_close;
    logic [CNT_WIDTH-1:0] edge_cnt;

    assign frame_close = o_VSYNC & ~vs_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_out_q      <= 1'b0;
            edge_cnt      <= '0;
            o_edge_count  <= '0;
            o_count_valid <= 1'b0;
        end else begin
            vs_out_q      <= o_VSYNC;
            o_count_valid <= frame_close;
            if (frame_close) begin
                // An edge on the boundary cycle belongs to the new frame.
                o_edge_count <= edge_cnt;
                edge_cnt     <= o_edge ? CNT_ONE : '0;
            end else if (o_edge && (edge_cnt != CNT_MAX)) begin
                edge_cnt <= edge_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_detector.sv
module tb_sobel_edge_detector;

    localparam int DW   = 8;
    localparam int CW   = 6;   // narrow counter so saturation is reachable
    localparam int CMAX = (1 << CW) - 1;

    localparam int KX[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam int KY[3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_VSYNC = 1'b0, i_HSYNC = 1'b0, i_BLANK = 1'b0;
    logic [DW-1:0] tap[3][3];
    logic [DW-1:0] i_threshold = 8'd64;
    logic          o_VSYNC, o_HSYNC, o_BLANK, o_edge, o_count_valid;
    logic [DW-1:0] o_mag;
    logic [CW-1:0] o_edge_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sobel_edge_detector #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .THRESH_DEFAULT(8'd64)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_VSYNC(i_VSYNC), .i_HSYNC(i_HSYNC), .i_BLANK(i_BLANK),
        .i_matrix11(tap[0][0]), .i_matrix12(tap[0][1]), .i_matrix13(tap[0][2]),
        .i_matrix21(tap[1][0]), .i_matrix22(tap[1][1]), .i_matrix23(tap[1][2]),
        .i_matrix31(tap[2][0]), .i_matrix32(tap[2][1]), .i_matrix33(tap[2][2]),
        .i_threshold(i_threshold),
        .o_VSYNC(o_VSYNC), .o_HSYNC(o_HSYNC), .o_BLANK(o_BLANK),
        .o_mag(o_mag), .o_edge(o_edge),
        .o_edge_count(o_edge_count), .o_count_valid(o_count_valid)
    );

    // ---------------- reference model ----------------
    // Per captured clock edge: what the pixel taken on that edge should become.
    bit r_ok[8], r_vs[8], r_hs[8], r_bl[8], r_edge[8];
    int r_mag[8];
    int ecnt = 0;
    int wi;
    int m_thr = 64;
    bit m_vsprev = 0;

    // Frame counter model, driven by the expected output stream.
    int m_cnt = 0, m_cnt_out = 0, m_pend_val = 0;
    bit m_pend = 0, m_ovs_prev = 0;

    function automatic int sobel_mag();
        int gx = 0, gy = 0, s;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                gx += KX[r][c] * int'(tap[r][c]);
                gy += KY[r][c] * int'(tap[r][c]);
            end
        s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (s > 255) ? 255 : s;
    endfunction

    always @(posedge clk) begin
        ecnt = ecnt + 1;
        wi = ecnt % 8;
        r_ok[wi] = rst_n;
        if (!rst_n) begin
            m_thr = 64;
            m_vsprev = 0;
        end else begin
            if (i_VSYNC && !m_vsprev) m_thr = int'(i_threshold);
            m_vsprev = i_VSYNC;
        end
        r_mag[wi]  = sobel_mag();
        r_edge[wi] = i_BLANK && (r_mag[wi] >= m_thr);
        r_vs[wi]   = i_VSYNC;
        r_hs[wi]   = i_HSYNC;
        r_bl[wi]   = i_BLANK;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, ecnt);
        end
    endtask

    task automatic check_outputs();
        int e, j;
        bit good;
        int x_vs, x_hs, x_bl, x_mag, x_edge, x_cv;
        e = ecnt;
        good = (e >= 2) && r_ok[e % 8] && r_ok[(e - 1) % 8] && r_ok[(e - 2) % 8];
        j = (e >= 2) ? (e - 2) % 8 : 0;
        x_vs   = good ? int'(r_vs[j]) : 0;
        x_hs   = good ? int'(r_hs[j]) : 0;
        x_bl   = good ? int'(r_bl[j]) : 0;
        x_mag  = (good && r_bl[j]) ? r_mag[j] : 0;
        x_edge = good ? int'(r_edge[j]) : 0;
        chk("o_VSYNC", 32'(o_VSYNC), x_vs);
        chk("o_HSYNC", 32'(o_HSYNC), x_hs);
        chk("o_BLANK", 32'(o_BLANK), x_bl);
        chk("o_mag", 32'(o_mag), x_mag);
        chk("o_edge", 32'(o_edge), x_edge);

        if (e < 1 || !r_ok[e % 8]) begin
            m_cnt = 0; m_cnt_out = 0; m_pend = 0; m_ovs_prev = 0;
            x_cv = 0;
        end else begin
            x_cv = int'(m_pend);
            if (m_pend) m_cnt_out = m_pend_val;
        end
        chk("o_count_valid", 32'(o_count_valid), x_cv);
        chk("o_edge_count", 32'(o_edge_count), m_cnt_out);

        if (e >= 1 && r_ok[e % 8]) begin
            if (x_vs == 1 && !m_ovs_prev) begin
                m_pend = 1;
                m_pend_val = m_cnt;
                m_cnt = x_edge;
            end else begin
                m_pend = 0;
                if (x_edge == 1 && m_cnt < CMAX) m_cnt++;
            end
            m_ovs_prev = (x_vs == 1);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        check_outputs();
    endtask

    // 0 flat, 1 hard vertical step, 2 weak right column, 3 random, 4 low contrast
    task automatic set_taps(input int kind);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                case (kind)
                    0: tap[r][c] = 8'd100;
                    1: tap[r][c] = (c == 0) ? 8'd0 : (c == 1) ? 8'd128 : 8'd255;
                    2: tap[r][c] = (c == 2) ? 8'd10 : 8'd0;
                    3: tap[r][c] = 8'($urandom_range(0, 255));
                    default: tap[r][c] = 8'($urandom_range(0, 15));
                endcase
    endtask

    task automatic run(input int n, input int kind, input bit bl);
        repeat (n) begin
            step();
            set_taps(kind);
            i_BLANK = bl;
            i_HSYNC = ~i_HSYNC;
        end
    endtask

    task automatic frame_start(input int thr);
        step();
        i_threshold = 8'(thr);
        i_VSYNC = 1'b1;
        step();
        i_VSYNC = 1'b0;
    endtask

    initial begin
        set_taps(0);
        repeat (3) step();
        rst_n = 1'b1;
        i_BLANK = 1'b1;

        run(10, 0, 1);                 // flat field: no gradient
        run(5, 1, 1);                  // saturating step at default threshold

        frame_start(40); run(6, 2, 1); // mag 40 vs threshold 40
        step(); i_threshold = 8'd41;   // ignored until next frame
        run(6, 2, 1);
        frame_start(41); run(6, 2, 1); // now below threshold

        frame_start(64);               // 640-pixel frame, 5 edges
        for (int p = 0; p < 640; p++)
            run(1, (p == 10 || p == 100 || p == 200 || p == 300 || p == 400) ? 1 : 0, 1);
        frame_start(64); run(100, 0, 1);
        frame_start(64); run(10, 0, 1);

        step(); i_VSYNC = 1'b1; set_taps(1);   // edge coinciding with the boundary
        step(); i_VSYNC = 1'b0; set_taps(0);
        run(10, 0, 1);
        frame_start(64); run(8, 0, 1);

        run(10, 1, 0);                 // step behind blanking
        run(3, 0, 1);

        frame_start(100);              // reset mid-frame after 3 edges
        run(3, 1, 1); run(3, 0, 1);
        step(); rst_n = 1'b0;
        step(); step(); rst_n = 1'b1;
        run(10, 1, 1);
        frame_start(64); run(10, 0, 1);

        for (int k = 0; k < 3000; k++) begin
            step();
            set_taps($urandom_range(0, 4));
            i_BLANK     = ($urandom_range(0, 3) != 0);
            i_HSYNC     = 1'($urandom_range(0, 1));
            i_threshold = 8'($urandom_range(0, 255));
            i_VSYNC     = ($urandom_range(0, 149) == 0) ? 1'b1 : (i_VSYNC & 1'($urandom_range(0, 1)));
            rst_n       = ($urandom_range(0, 799) != 0);
        end
        rst_n = 1'b1;
        run(10, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
